// File: rtl/pkt_gen_ctrl_pkg.sv
// Shared types and constants for the packet generator run controller.
package pkt_gen_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_WDOG = 2'b10;
   localparam logic [1:0] ERR_LEN  = 2'b11;

   // Header word plus the extra data word the generator adds on top of burst_len.
   localparam int HDR_WORDS = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts at one.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= W'(inc);
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pkt_gen_ctrl.sv
// Run controller for the write-packetizer test generator: configures, counts,
// length-checks and stops the generator, aborting on overflow or watchdog.
module pkt_gen_ctrl
   import pkt_gen_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH  = 32,
   parameter int CLR_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [31:0]          cfg_num_pkts,
   input  logic [31:0]          cfg_burst_len,
   input  logic [31:0]          cfg_sleep,
   input  logic [CNT_WIDTH-1:0] cfg_watchdog,
   input  logic                 gen_valid,
   input  logic                 tx_overflow,
   output logic                 gen_en,
   output logic                 gen_rst,
   output logic [31:0]          burst_len,
   output logic [31:0]          sleep_write,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [CNT_WIDTH-1:0] valid_cycles
);

   localparam int LW = (CNT_WIDTH > 33) ? CNT_WIDTH : 33;

   state_t               state, state_n;
   logic [1:0]           code_n;
   logic [3:0]           clr_cnt;
   logic [31:0]          num_pkts;
   logic [CNT_WIDTH-1:0] wd_lim, wd_cnt, len_cnt;
   logic                 valid_q, pkt_end_q, ovf_q;
   logic                 active, accept_start, len_ok, last_pkt, wd_trip, in_flight;

   assign active       = (state == ST_RUN) || (state == ST_DRAIN);
   assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign len_ok       = LW'(len_cnt) == (LW'(burst_len) + LW'(HDR_WORDS));
   assign last_pkt     = (num_pkts != '0) && ((LW'(pkt_count) + LW'(1)) == LW'(num_pkts));
   assign wd_trip      = (wd_lim != '0) && (wd_cnt >= (wd_lim - CNT_WIDTH'(1)));
   assign in_flight    = gen_valid || valid_q;

   // Overflow beats length error beats watchdog when they land together.
   always_comb begin
      state_n = state;
      code_n  = ERR_NONE;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_n = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (ovf_q) begin
               state_n = ST_ERR;
               code_n  = ERR_OVF;
            end else if (stop) begin
               state_n = in_flight ? ST_DRAIN : ST_DONE;
            end else if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
               state_n = ST_RUN;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (ovf_q) begin
               state_n = ST_ERR;
               code_n  = ERR_OVF;
            end else if (pkt_end_q && !len_ok) begin
               state_n = ST_ERR;
               code_n  = ERR_LEN;
            end else if (wd_trip) begin
               state_n = ST_ERR;
               code_n  = ERR_WDOG;
            end else if (pkt_end_q && ((state == ST_DRAIN) || last_pkt)) begin
               state_n = ST_DONE;
            end else if (stop && (state == ST_RUN)) begin
               state_n = in_flight ? ST_DRAIN : ST_DONE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         clr_cnt     <= '0;
         num_pkts    <= '0;
         wd_lim      <= '0;
         burst_len   <= '0;
         sleep_write <= '0;
         valid_q     <= 1'b0;
         pkt_end_q   <= 1'b0;
         ovf_q       <= 1'b0;
         gen_en      <= 1'b0;
         gen_rst     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         state     <= state_n;
         valid_q   <= active && gen_valid;
         pkt_end_q <= active && valid_q && !gen_valid;
         ovf_q     <= tx_overflow && (active || (state == ST_CLEAR));
         clr_cnt   <= (state == ST_CLEAR) ? clr_cnt + 4'd1 : 4'd0;
         if (accept_start) begin
            num_pkts    <= cfg_num_pkts;
            wd_lim      <= cfg_watchdog;
            burst_len   <= cfg_burst_len;
            sleep_write <= cfg_sleep;
         end
         // Outputs are decoded from the next state so they change with the state register.
         gen_en  <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
         gen_rst <= (state_n == ST_CLEAR);
         busy    <= (state_n == ST_CLEAR) || (state_n == ST_RUN) || (state_n == ST_DRAIN);
         done    <= (state_n == ST_DONE);
         error   <= (state_n == ST_ERR);
         if (state_n != ST_ERR) err_code <= ERR_NONE;
         else if (state != ST_ERR) err_code <= code_n;
      end
   end

   sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
      .clk(clk), .rst(rst), .clr(accept_start), .inc(active && pkt_end_q), .cnt(pkt_count)
   );

   sat_counter #(.W(CNT_WIDTH)) u_valid_cnt (
      .clk(clk), .rst(rst), .clr(accept_start), .inc(active && gen_valid), .cnt(valid_cycles)
   );

   sat_counter #(.W(CNT_WIDTH)) u_wd_cnt (
      .clk(clk), .rst(rst), .clr(!active || pkt_end_q), .inc(active && !pkt_end_q), .cnt(wd_cnt)
   );

   sat_counter #(.W(CNT_WIDTH)) u_len_cnt (
      .clk(clk), .rst(rst), .clr(!active || pkt_end_q), .inc(active && gen_valid), .cnt(len_cnt)
   );

endmodule

// File: doc/pkt_gen_ctrl.md
# pkt_gen_ctrl

Run controller for the 10GbE write-packetizer test generator. Latches a run configuration, drives the generator's `en`/`rst`/`burst_len`/`sleep_write` inputs, counts and length-checks the packets it emits, and stops cleanly after a programmed packet count. It also aborts on packetizer overflow or a watchdog timeout. It sits between the register/software interface and the generator, one instance per generator.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of packet counter, valid-cycle counter and watchdog.
- `CLR_CYCLES`, 2, number of cycles `gen_rst` is held at run start (1..15).

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run. Honoured only in IDLE, DONE or ERR.
- `stop`  in  1  one-cycle pulse; requests a graceful stop at the next packet end.
- `cfg_num_pkts`  in  32  number of packets to run; 0 means run until `stop`.
- `cfg_burst_len`  in  32  burst length passed to the generator.
- `cfg_sleep`  in  32  sleep cycles passed to the generator.
- `cfg_watchdog`  in  CNT_WIDTH  maximum number of cycles without a packet end; 0 disables the watchdog.
- `gen_valid`  in  1  `dout_valid` from the generator.
- `tx_overflow`  in  1  overflow flag from the packetizer.
- `gen_en`  out  1  generator enable.
- `gen_rst`  out  1  generator synchronous reset.
- `burst_len`  out  32  latched burst length.
- `sleep_write`  out  32  latched sleep count.
- `busy`  out  1  high in CLEAR, RUN and DRAIN.
- `done`  out  1  high in DONE, until the next `start`.
- `error`  out  1  high in ERR, until the next `start`.
- `err_code`  out  2  01 overflow, 10 watchdog, 11 length error. Held in ERR; 00 otherwise.
- `pkt_count`  out  CNT_WIDTH  number of packets completed in the current run.
- `valid_cycles`  out  CNT_WIDTH  total `gen_valid` high cycles in the current run.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE, ERR.
- **IDLE/DONE/ERR + `start`** -> CLEAR:
  - latch `cfg_*` into `burst_len`, `sleep_write` and internal `num_pkts` / `watchdog` registers;
  - zero `pkt_count`, `valid_cycles` and `err_code`.
- **CLEAR:** `gen_rst`=1, `gen_en`=0 for CLR_CYCLES cycles, then -> RUN.
- **RUN:** `gen_en`=1.
  - Packet end = `gen_valid` falling edge, detected from a registered copy of `gen_valid`.
  - Every packet is required to be exactly `burst_len`+2 valid cycles (header word plus `burst_len`+1 data words).
  - On packet end: `pkt_count`+1, and the run-length counter is compared with `burst_len`+2. A mismatch goes to ERR with code 11.
  - If `num_pkts`≠0 and the incremented `pkt_count`==`num_pkts` -> DONE.
- **`stop`** in CLEAR or RUN:
  - sets a stop flag;
  - if `gen_valid` is low and no packet is in progress -> DONE immediately;
  - otherwise -> DRAIN.
- **DRAIN:** `gen_en` stays 1 until the packet end. That end is counted and length-checked, then -> DONE.
- **Watchdog (RUN/DRAIN):** counts cycles since the last packet end or since entering RUN. Reaching `cfg_watchdog` (nonzero) -> ERR, code 10.
- **`tx_overflow`** high in CLEAR/RUN/DRAIN -> ERR, code 01.
- **ERR priority** when several conditions hit in the same cycle: overflow > length > watchdog.
- **Counters:** `valid_cycles` increments in RUN and DRAIN whenever `gen_valid`=1. All counters saturate at all-ones; they do not wrap.
- **DONE/ERR:** `gen_en`=0 and `gen_rst`=0. Counters are frozen and readable.
- `start` while `busy` is ignored. `stop` outside CLEAR/RUN/DRAIN is ignored.

## Timing
- **Reset values:**
  - state IDLE;
  - `gen_en`, `gen_rst`, `busy`, `done`, `error` = 0;
  - `err_code`, `pkt_count`, `valid_cycles`, `burst_len`, `sleep_write` = 0.
- All outputs are registered.
- `start` at edge N: `gen_rst`=1 and `busy`=1 visible after edge N. `gen_en`=1 after edge N+CLR_CYCLES.
- A `gen_valid` falling edge first seen at edge M:
  - `pkt_count` updated after edge M+1;
  - if it is the final packet, `gen_en`=0 and `done`=1 after edge M+1.
- A `stop` with no packet in flight gives `done` one cycle later.
- `tx_overflow` at edge K gives `gen_en`=0 and `error`=1 after edge K+1.
- `rst` mid-run asserts immediately, without waiting for a clock edge: `gen_en` drops at once and all state clears.

## Structure
- A shared package `pkt_gen_ctrl_pkg` holds:
  - the state enum;
  - `err_code` constants (ERR_NONE, ERR_OVF, ERR_WDOG, ERR_LEN);
  - `HDR_WORDS`=2, the constant added to `burst_len` for the expected length.
- One natural sub-module, `sat_counter` (parameterised width, `clr`, `inc`, saturating). It is instantiated for `pkt_count`, `valid_cycles`, the watchdog and the per-packet length counter.

## Test plan
- **Normal run:** `cfg_num_pkts`=3, `burst_len`=4, `sleep`=5, real generator attached -> `done`=1, `pkt_count`=3, `valid_cycles`=18, `error`=0.
- **Graceful stop:** `num_pkts`=0, `stop` pulsed in the middle of the second packet -> DRAIN, `done` after that packet ends, `pkt_count`=2.
- **Length error:** stub generator emits a 5-cycle valid run with `burst_len`=4 -> `error`=1, `err_code`=11, `pkt_count`=1.
- **Overflow:** `tx_overflow` pulsed during the first packet -> `error`=1, `err_code`=01, `gen_en`=0 one cycle later.
- **Watchdog:** `cfg_watchdog`=20, `sleep`=100 -> `error`=1, `err_code`=10 at cycle 20 of RUN.
- **Async reset and restart:** `rst` asserted mid-RUN between clock edges -> all outputs equal their reset values immediately. A subsequent `start` runs normally, and a `start` while `busy` is ignored.
